// File: rtl/fifo_tg_pkg.sv
// Shared types and constants for the FIFO traffic generator.
package fifo_tg_pkg;

  typedef enum logic [1:0] {
    FILL_DRAIN = 2'd0,
    STREAM     = 2'd1,
    RANDOM     = 2'd2,
    RSVD       = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_STREAM,
    ST_RANDOM,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/tg_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and shift enable.
module tg_lfsr16
  import fifo_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fifo_traffic_gen.sv
// Drives an incrementing word sequence into a FIFO under flow control and
// checks the read-back sequence, counting miscompares.
module fifo_traffic_gen
  import fifo_tg_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          CNT_W     = 16,
  parameter int          RD_LAT    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_items,
  input  logic             full,
  input  logic             empty,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, wr_cnt_q, rd_cnt_q, chk_cnt_q, num_m1;
  logic [ERR_W-1:0] err_q;
  logic             rd_en_q, mismatch_q;
  logic             accept, wr_ok, rd_ok, rd_vld, miscmp;
  logic [15:0]      lfsr;
  logic             unused_lfsr;

  tg_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .en_i    (state_q == ST_RANDOM),
    .state_o (lfsr)
  );
  assign unused_lfsr = ^lfsr[15:2];

  assign accept = start && (state_q == ST_IDLE);
  assign num_m1 = num_q - CNT_W'(1);
  assign wr_ok  = !full && (wr_cnt_q < num_q);
  assign rd_ok  = !empty && (rd_cnt_q < num_q);
  assign rd_vld = (RD_LAT == 0) ? rd_en : rd_en_q;
  assign miscmp = rd_vld && (rd_data != chk_cnt_q[WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_items == '0) begin
            state_d = ST_DONE;
          end else begin
            case (mode_e'(mode))
              FILL_DRAIN: state_d = ST_FILL;
              RANDOM:     state_d = ST_RANDOM;
              default:    state_d = ST_STREAM;
            endcase
          end
        end
      end
      ST_FILL: begin
        wr_en = wr_ok;
        if (full || (wr_ok && wr_cnt_q == num_m1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        rd_en = rd_ok;
        if (rd_ok && rd_cnt_q == num_m1) state_d = ST_FLUSH;
        else if (empty)                  state_d = ST_FILL;
      end
      ST_STREAM: begin
        wr_en = wr_ok;
        rd_en = rd_ok;
        if (rd_ok && rd_cnt_q == num_m1) state_d = ST_FLUSH;
      end
      ST_RANDOM: begin
        wr_en = wr_ok && lfsr[0];
        rd_en = rd_ok && lfsr[1];
        if (rd_en && rd_cnt_q == num_m1) state_d = ST_FLUSH;
      end
      // Wait for the last read word to be checked when RD_LAT delays it
      ST_FLUSH: begin
        if (chk_cnt_q == num_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      chk_cnt_q  <= '0;
      err_q      <= '0;
      rd_en_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en;
      mismatch_q <= miscmp;
      if (accept) begin
        num_q     <= num_items;
        wr_cnt_q  <= '0;
        rd_cnt_q  <= '0;
        chk_cnt_q <= '0;
        err_q     <= '0;
      end else begin
        if (wr_en)  wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
        if (rd_en)  rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
        if (rd_vld) chk_cnt_q <= chk_cnt_q + CNT_W'(1);
        if (miscmp) err_q     <= sat_inc(err_q);
      end
    end
  end

  assign wr_data   = wr_cnt_q[WIDTH-1:0];
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench: two generators (FWFT and one-cycle-latency FIFO models, depth 64)
// driven in lockstep and checked against a scoreboard of the write/read rules.
module tb_fifo_traffic_gen;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_items = 16'd0;

  logic [1:0]      full, empty, wr_en, rd_en, busy, done, mismatch;
  logic [1:0][7:0] wr_data, rd_data, err_count;
  logic [7:0]      rdat1_q;

  logic [7:0] mem [2][DEPTH];
  int wp [2], rp [2], cnt [2], nrd [2];
  int corrupt_idx = -1;
  int cyc = 0;
  int run_num = 0;
  int n_checks = 0, n_fail = 0;

  int wr_seen [2], rd_seen [2], done_cnt [2], mm_cnt [2], viol [2], wdat_err [2];
  int ovl [2], gaps [2], wr_before_rd [2], done_cyc [2], last_rd_cyc [2], err_at_done [2];

  always #5 clk = ~clk;

  fifo_traffic_gen #(.WIDTH(8), .CNT_W(16), .RD_LAT(0), .LFSR_SEED(16'hACE1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_items(num_items),
    .full(full[0]), .empty(empty[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]),
    .mismatch(mismatch[0]), .err_count(err_count[0]));

  fifo_traffic_gen #(.WIDTH(8), .CNT_W(16), .RD_LAT(1), .LFSR_SEED(16'hACE1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_items(num_items),
    .full(full[1]), .empty(empty[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]),
    .mismatch(mismatch[1]), .err_count(err_count[1]));

  assign full[0]    = (cnt[0] == DEPTH);
  assign full[1]    = (cnt[1] == DEPTH);
  assign empty[0]   = (cnt[0] == 0);
  assign empty[1]   = (cnt[1] == 0);
  assign rd_data[0] = (nrd[0] == corrupt_idx) ? 8'h55 : mem[0][rp[0]];
  assign rd_data[1] = rdat1_q;

  // FIFO models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= 0; rp[i] <= 0; cnt[i] <= 0; nrd[i] <= 0;
      end
      rdat1_q <= 8'h00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i] && cnt[i] < DEPTH) begin
          mem[i][wp[i]] <= wr_data[i];
          wp[i] <= (wp[i] + 1) % DEPTH;
        end
        if (rd_en[i] && cnt[i] > 0) begin
          rp[i]  <= (rp[i] + 1) % DEPTH;
          nrd[i] <= nrd[i] + 1;
        end
        cnt[i] <= cnt[i] + ((wr_en[i] && cnt[i] < DEPTH) ? 1 : 0) - ((rd_en[i] && cnt[i] > 0) ? 1 : 0);
      end
      if (rd_en[1] && cnt[1] > 0) rdat1_q <= (nrd[1] == corrupt_idx) ? 8'h55 : mem[1][rp[1]];
    end
  end

  // Scoreboard statistics, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        wr_seen[i] <= 0; rd_seen[i] <= 0; done_cnt[i] <= 0; mm_cnt[i] <= 0;
        viol[i] <= 0; wdat_err[i] <= 0; ovl[i] <= 0; gaps[i] <= 0;
        wr_before_rd[i] <= -1; done_cyc[i] <= -1; last_rd_cyc[i] <= -1; err_at_done[i] <= -1;
      end else begin
        if (wr_en[i]) begin
          wr_seen[i] <= wr_seen[i] + 1;
          if (full[i]) viol[i] <= viol[i] + 1;
          if (wr_data[i] !== 8'(wr_seen[i])) wdat_err[i] <= wdat_err[i] + 1;
        end
        if (rd_en[i]) begin
          if (empty[i]) viol[i] <= viol[i] + 1;
          if (rd_seen[i] == 0) wr_before_rd[i] <= wr_seen[i];
          rd_seen[i] <= rd_seen[i] + 1;
          last_rd_cyc[i] <= cyc;
        end
        if (wr_en[i] && rd_en[i]) ovl[i] <= ovl[i] + 1;
        if (busy[i] && !wr_en[i] && !full[i] && wr_seen[i] < run_num) gaps[i] <= gaps[i] + 1;
        if (done[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          done_cyc[i] <= cyc;
          err_at_done[i] <= int'(err_count[i]);
        end
        if (mismatch[i]) mm_cnt[i] <= mm_cnt[i] + 1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic launch(input logic [1:0] m, input int n, output int acc);
    run_num = n; mode = m; num_items = 16'(n); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && k < budget) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (!(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
      n_fail++; $display("FAIL %s_timeout: done counts %0d/%0d after %0d cycles, required 1", tag, done_cnt[0], done_cnt[1], k);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({wr_en[i], rd_en[i], busy[i], done[i], mismatch[i]} !== 5'b0) begin
        n_fail++; $display("FAIL reset_strobes[%0d]: got %b required 00000", i, {wr_en[i], rd_en[i], busy[i], done[i], mismatch[i]});
      end
      n_checks++;
      if (err_count[i] !== 8'h00) begin n_fail++; $display("FAIL reset_err[%0d]: got %0h required 0", i, err_count[i]); end
      n_checks++;
      if (wr_data[i] !== 8'h00) begin n_fail++; $display("FAIL reset_wdata[%0d]: got %0h required 0", i, wr_data[i]); end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_fill_drain(input int n);
    int acc;
    do_reset();
    launch(2'd0, n, acc);
    wait_done(3000, "fill_drain");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_seen[i] !== n) begin n_fail++; $display("FAIL fd%0d_writes[%0d]: got %0d required %0d", n, i, wr_seen[i], n); end
      n_checks++;
      if (rd_seen[i] !== n) begin n_fail++; $display("FAIL fd%0d_reads[%0d]: got %0d required %0d", n, i, rd_seen[i], n); end
      n_checks++;
      if (wr_before_rd[i] !== DEPTH) begin n_fail++; $display("FAIL fd%0d_first_fill[%0d]: got %0d required %0d", n, i, wr_before_rd[i], DEPTH); end
      n_checks++;
      if (done_cnt[i] !== 1) begin n_fail++; $display("FAIL fd%0d_done[%0d]: got %0d pulses required 1", n, i, done_cnt[i]); end
      n_checks++;
      if (err_at_done[i] !== 0 || mm_cnt[i] !== 0) begin
        n_fail++; $display("FAIL fd%0d_errors[%0d]: err %0d mismatches %0d required 0/0", n, i, err_at_done[i], mm_cnt[i]);
      end
      n_checks++;
      if (viol[i] !== 0 || wdat_err[i] !== 0) begin
        n_fail++; $display("FAIL fd%0d_protocol[%0d]: flag violations %0d data errors %0d required 0/0", n, i, viol[i], wdat_err[i]);
      end
      n_checks++;
      if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL fd%0d_busy_after[%0d]: got %b required 0", n, i, busy[i]); end
    end
  endtask

  task automatic test_stream();
    int acc;
    do_reset();
    launch(2'd1, 16, acc);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; num_items = 16'd5;
    @(posedge clk); #1 start = 1'b0; num_items = 16'd16;
    wait_done(500, "stream");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_seen[i] !== 16 || rd_seen[i] !== 16) begin
        n_fail++; $display("FAIL stream_counts[%0d]: wr %0d rd %0d required 16/16", i, wr_seen[i], rd_seen[i]);
      end
      n_checks++;
      if (ovl[i] == 0) begin n_fail++; $display("FAIL stream_overlap[%0d]: got %0d overlapping cycles required >0", i, ovl[i]); end
      n_checks++;
      if (gaps[i] !== 0) begin n_fail++; $display("FAIL stream_gaps[%0d]: got %0d idle write cycles required 0", i, gaps[i]); end
      n_checks++;
      if (done_cyc[i] !== last_rd_cyc[i] + 2 + i) begin
        n_fail++; $display("FAIL stream_done_latency[%0d]: done at %0d last read %0d required +%0d", i, done_cyc[i], last_rd_cyc[i], 2 + i);
      end
      n_checks++;
      if (err_at_done[i] !== 0 || viol[i] !== 0 || wdat_err[i] !== 0) begin
        n_fail++; $display("FAIL stream_clean[%0d]: err %0d viol %0d data %0d required 0", i, err_at_done[i], viol[i], wdat_err[i]);
      end
    end
  endtask

  task automatic test_mode3();
    int acc;
    do_reset();
    launch(2'd3, 20, acc);
    wait_done(500, "mode3");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rd_seen[i] !== 20 || gaps[i] !== 0 || err_at_done[i] !== 0) begin
        n_fail++; $display("FAIL mode3[%0d]: rd %0d gaps %0d err %0d required 20/0/0", i, rd_seen[i], gaps[i], err_at_done[i]);
      end
    end
  endtask

  task automatic test_random_300();
    int acc;
    do_reset();
    launch(2'd2, 300, acc);
    wait_done(20000, "random300");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_seen[i] !== 300 || rd_seen[i] !== 300) begin
        n_fail++; $display("FAIL rnd_counts[%0d]: wr %0d rd %0d required 300/300", i, wr_seen[i], rd_seen[i]);
      end
      n_checks++;
      if (viol[i] !== 0) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %0d strobes against full/empty required 0", i, viol[i]); end
      n_checks++;
      if (wdat_err[i] !== 0) begin n_fail++; $display("FAIL rnd_wrap_data[%0d]: got %0d bad write words required 0", i, wdat_err[i]); end
      n_checks++;
      if (err_at_done[i] !== 0) begin n_fail++; $display("FAIL rnd_err[%0d]: got %0d required 0", i, err_at_done[i]); end
      n_checks++;
      if (gaps[i] == 0) begin n_fail++; $display("FAIL rnd_irregular[%0d]: got %0d withheld writes required >0", i, gaps[i]); end
    end
  endtask

  task automatic test_corrupt();
    int acc;
    do_reset();
    corrupt_idx = 5;
    launch(2'd0, 16, acc);
    wait_done(500, "corrupt");
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mm_cnt[i] !== 1) begin n_fail++; $display("FAIL corrupt_pulses[%0d]: got %0d required 1", i, mm_cnt[i]); end
      n_checks++;
      if (err_at_done[i] !== 1) begin n_fail++; $display("FAIL corrupt_err_done[%0d]: got %0d required 1", i, err_at_done[i]); end
      n_checks++;
      if (err_count[i] !== 8'd1) begin n_fail++; $display("FAIL corrupt_err_hold[%0d]: got %0d required 1", i, err_count[i]); end
    end
    corrupt_idx = -1;
  endtask

  task automatic test_rst_mid_fill();
    int acc;
    int k = 0;
    do_reset();
    launch(2'd0, 50, acc);
    while (wr_seen[0] < 10 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (wr_seen[0] < 10) begin n_fail++; $display("FAIL abort_reach10: got %0d writes required 10", wr_seen[0]); end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({wr_en[i], rd_en[i], busy[i], done[i]} !== 4'b0 || wr_data[i] !== 8'h00 || err_count[i] !== 8'h00) begin
        n_fail++; $display("FAIL abort_outputs[%0d]: strobes %b wdata %0h err %0h required 0", i, {wr_en[i], rd_en[i], busy[i], done[i]}, wr_data[i], err_count[i]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (wr_seen[i] !== 0 || rd_seen[i] !== 0 || busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet[%0d]: wr %0d rd %0d busy %b required 0", i, wr_seen[i], rd_seen[i], busy[i]);
      end
    end
    launch(2'd0, 0, acc);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (done_cnt[i] !== 1 || done_cyc[i] !== acc) begin
        n_fail++; $display("FAIL zero_items_done[%0d]: pulses %0d at cycle %0d required 1 at %0d", i, done_cnt[i], done_cyc[i], acc);
      end
      n_checks++;
      if (wr_seen[i] !== 0 || rd_seen[i] !== 0) begin
        n_fail++; $display("FAIL zero_items_strobes[%0d]: wr %0d rd %0d required 0/0", i, wr_seen[i], rd_seen[i]);
      end
    end
  endtask

  task automatic test_random_runs();
    int acc, n;
    logic [1:0] m;
    for (int r = 0; r < 4; r++) begin
      m = 2'($urandom_range(0, 3));
      n = int'($urandom_range(1, 150));
      do_reset();
      launch(m, n, acc);
      wait_done(6000, "random_run");
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (wr_seen[i] !== n || rd_seen[i] !== n || done_cnt[i] !== 1) begin
          n_fail++; $display("FAIL run%0d_m%0d_n%0d[%0d]: wr %0d rd %0d done %0d required %0d/%0d/1", r, m, n, i, wr_seen[i], rd_seen[i], done_cnt[i], n, n);
        end
        n_checks++;
        if (err_at_done[i] !== 0 || viol[i] !== 0 || wdat_err[i] !== 0) begin
          n_fail++; $display("FAIL run%0d_clean[%0d]: err %0d viol %0d data %0d required 0", r, i, err_at_done[i], viol[i], wdat_err[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain(64);
    test_fill_drain(100);
    test_stream();
    test_mode3();
    test_random_300();
    test_corrupt();
    test_rst_mid_fill();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
Parametrised stimulus-and-check engine for the synchronous FIFO in bring-up and self-test benches. It drives a programmable number of incrementing data words into the FIFO under full/empty flow control, in one of three traffic modes. It reads the words back and checks them against the expected sequence, counting mismatches. It sits beside the FIFO in place of the earlier fixed fill-then-drain generator.

Parameters:
WIDTH, 8, data width of wr_data/rd_data
CNT_W, 16, width of item counters and num_items
RD_LAT, 0, FIFO read latency: 0 = rd_data valid in the rd_en cycle (FWFT); 1 = valid one cycle after rd_en
LFSR_SEED, 16'hACE1, nonzero seed for the random-mode LFSR
ERR_W, 8, width of err_count (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
mode  in  2  0 = FILL_DRAIN, 1 = STREAM, 2 = RANDOM, 3 = reserved (behaves as STREAM)
num_items  in  CNT_W  words to write and read in this run
full  in  1  FIFO full flag
empty  in  1  FIFO empty flag
wr_en  out  1  FIFO write strobe
wr_data  out  WIDTH  write data
rd_en  out  1  FIFO read strobe
rd_data  in  WIDTH  FIFO read data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
mismatch  out  1  one-cycle pulse per read-data miscompare
err_count  out  ERR_W  miscompares this run; saturates at all-ones

Behaviour:
- Reset values: FSM=IDLE; all counters 0; LFSR=LFSR_SEED; rd-valid pipe 0. wr_en, rd_en, busy, done, mismatch=0. err_count=0, wr_data=0.
- Reset mid-run aborts the run. Next cycle all outputs are at reset values and no strobes are issued.
- start is accepted only in IDLE; ignored otherwise. On accept: latch mode and num_items, clear wr_cnt/rd_cnt/chk_cnt/err_count, reload the LFSR.
- num_items==0: go straight to DONE; done rises the cycle after start.
- wr_data = wr_cnt[WIDTH-1:0], registered. Sequence is 0,1,2,… and wraps mod 2^WIDTH. wr_cnt increments on each wr_en.
- wr_en and rd_en are combinational from registered state plus full/empty. Never wr_en with full; never rd_en with empty. wr_en only while wr_cnt<num_items; rd_en only while rd_cnt<num_items.
- FSM states: IDLE, FILL, DRAIN, STREAM, RANDOM, FLUSH, DONE.
- FILL (mode 0): wr_en=!full. Go to DRAIN when wr_cnt reaches num_items or full is seen.
- DRAIN: rd_en=!empty. When empty and rd_cnt<num_items, return to FILL. When rd_cnt==num_items, go to FLUSH. This handles num_items > FIFO depth in multiple passes.
- STREAM (modes 1/3): wr_en and rd_en are evaluated independently every cycle; simultaneous read and write are allowed.
- RANDOM (mode 2): as STREAM, with wr_en additionally gated by lfsr[0] and rd_en by lfsr[1]. LFSR is 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in RANDOM.
- Read-valid: RD_LAT=0 means rd_vld=rd_en. RD_LAT=1 means rd_vld=rd_en delayed one cycle.
- On rd_vld, compare rd_data with chk_cnt[WIDTH-1:0], then increment chk_cnt. On miscompare, mismatch pulses the next cycle and err_count increments unless already all-ones.
- FLUSH: wait until chk_cnt==num_items (covers the RD_LAT=1 tail), then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. err_count holds its value until the next accepted start.

Decomposition:
- Package fifo_tg_pkg: mode_e enum (FILL_DRAIN, STREAM, RANDOM, RSVD), state_e enum, LFSR tap constant.
- Sub-module tg_lfsr16: seed load, enable, 16-bit state out.

Test Plan:
- FIFO depth 64, mode 0, num_items=64 -> 64 consecutive writes 0..63 until full, then 64 reads returning 0..63; done pulses once; err_count=0.
- Depth 64, mode 0, num_items=100 -> fill 64, drain 64, fill 36, drain 36; 100 reads in order; err_count=0.
- Mode 1, num_items=16, RD_LAT=1 -> overlapping wr_en/rd_en observed; 16 reads compare 0..15; done only after 16th check.
- Mode 2, num_items=300, WIDTH=8 -> irregular strobes; data wraps 255->0 without error; never wr_en&&full or rd_en&&empty; err_count=0.
- Bench corrupts 6th read word (expected 5, drive 8'h55) -> single mismatch pulse; err_count=1 at done.
- rst asserted mid-FILL at wr_cnt=10 -> next cycle wr_en=rd_en=busy=0, wr_data=0. A new start with num_items=0 -> done the following cycle.
